// File: rtl/miriscv_irq_ctrl.sv
// rtl/miriscv_irq_ctrl.sv - masked fixed-priority / round-robin interrupt controller
// One interrupt in flight: int_o pulse, wait for handler return, one-cycle int_fin_o acknowledge.
module miriscv_irq_ctrl #(
   parameter int N_IRQ       = 32,
   parameter int ROUND_ROBIN = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_IRQ-1:0] int_req_i,
   input  logic [N_IRQ-1:0] mie_i,
   input  logic             int_rst_i,
   output logic             int_o,
   output logic [31:0]      mcause_o,
   output logic [N_IRQ-1:0] int_fin_o
);

   typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

   localparam logic [4:0] LAST_ID_RST = 5'(N_IRQ - 1);
   localparam logic [5:0] N_IRQ_W     = 6'(N_IRQ);

   state_t             state, state_nxt;
   logic [4:0]         id, id_nxt;
   logic [4:0]         last_id, last_id_nxt;
   logic               int_nxt;
   logic [31:0]        mcause_nxt;
   logic [N_IRQ-1:0]   fin_nxt;
   logic [31:0]        pend;
   logic [31:0]        fin_onehot;
   logic [5:0]         start;
   logic [5:0]         idx;
   logic [4:0]         win;
   logic               found;

   // Winner search walks the lines from start, wrapping at N_IRQ; first pending line wins.
   always_comb begin
      pend = '0;
      pend[N_IRQ-1:0] = int_req_i & mie_i;
      start = ((ROUND_ROBIN != 0) && (last_id != LAST_ID_RST)) ? ({1'b0, last_id} + 6'd1) : 6'd0;
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int j = 0; j < N_IRQ; j++) begin
         idx = start + 6'(j);
         if (idx >= N_IRQ_W) begin
            idx = idx - N_IRQ_W;
         end
         if (!found && pend[idx[4:0]]) begin
            win   = idx[4:0];
            found = 1'b1;
         end
      end
   end

   assign fin_onehot = 32'd1 << id;

   always_comb begin
      state_nxt   = state;
      id_nxt      = id;
      last_id_nxt = last_id;
      int_nxt     = 1'b0;
      mcause_nxt  = mcause_o;
      fin_nxt     = '0;
      case (state)
         IDLE: begin
            if (found) begin
               id_nxt      = win;
               last_id_nxt = win;
               mcause_nxt  = {1'b1, 26'b0, win};
               int_nxt     = 1'b1;
               state_nxt   = BUSY;
            end
         end
         BUSY: begin
            if (int_rst_i) begin
               fin_nxt   = fin_onehot[N_IRQ-1:0];
               state_nxt = FIN;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         id        <= '0;
         last_id   <= LAST_ID_RST;
         int_o     <= 1'b0;
         mcause_o  <= '0;
         int_fin_o <= '0;
      end else begin
         state     <= state_nxt;
         id        <= id_nxt;
         last_id   <= last_id_nxt;
         int_o     <= int_nxt;
         mcause_o  <= mcause_nxt;
         int_fin_o <= fin_nxt;
      end
   end

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// tb/tb_miriscv_irq_ctrl.sv - bench for miriscv_irq_ctrl, fixed-priority and round-robin instances
// A request/acknowledge model predicts both instances every cycle; directed tests pin literal values.
module tb_miriscv_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] req;
   logic [31:0] mie;
   logic        int_rst;

   logic        int_f, int_r;
   logic [31:0] mc_f, mc_r;
   logic [31:0] fin_f, fin_r;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   miriscv_irq_ctrl #(.N_IRQ(32), .ROUND_ROBIN(0)) u_fix (
      .clk_i(clk), .rst_i(rst), .int_req_i(req), .mie_i(mie), .int_rst_i(int_rst),
      .int_o(int_f), .mcause_o(mc_f), .int_fin_o(fin_f)
   );

   miriscv_irq_ctrl #(.N_IRQ(32), .ROUND_ROBIN(1)) u_rr (
      .clk_i(clk), .rst_i(rst), .int_req_i(req), .mie_i(mie), .int_rst_i(int_rst),
      .int_o(int_r), .mcause_o(mc_r), .int_fin_o(fin_r)
   );

   // Model: index 0 is the fixed-priority instance, index 1 the round-robin one.
   // ph: 0 = free to take a request, 1 = handler running, 2 = acknowledge cycle.
   int          ph [2];
   int          last [2];
   int          m_id [2];
   logic        e_int [2];
   logic [31:0] e_mc [2];
   logic [31:0] e_fin [2];
   logic        model_live = 1'b0;

   function automatic int pick(input logic [31:0] p, input int from);
      for (int k = 0; k < 32; k++) begin
         if (p[(from + k) % 32]) return (from + k) % 32;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            ph[d]    <= 0;
            last[d]  <= 31;
            m_id[d]  <= 0;
            e_int[d] <= 1'b0;
            e_fin[d] <= 32'h0;
            e_mc[d]  <= 32'h0;
         end else begin
            e_int[d] <= 1'b0;
            e_fin[d] <= 32'h0;
            if (ph[d] == 0 && (req & mie) != 32'h0) begin
               e_int[d] <= 1'b1;
               m_id[d]  <= pick(req & mie, (d == 1) ? (last[d] + 1) % 32 : 0);
               last[d]  <= pick(req & mie, (d == 1) ? (last[d] + 1) % 32 : 0);
               e_mc[d]  <= 32'h8000_0000 | 32'(pick(req & mie, (d == 1) ? (last[d] + 1) % 32 : 0));
               ph[d]    <= 1;
            end else if (ph[d] == 1 && int_rst) begin
               e_fin[d] <= 32'd1 << m_id[d];
               ph[d]    <= 2;
            end else if (ph[d] == 2) begin
               ph[d] <= 0;
            end
         end
      end
      model_live <= 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         chk("model_int_fix", {31'b0, int_f}, {31'b0, e_int[0]});
         chk("model_mc_fix", mc_f, e_mc[0]);
         chk("model_fin_fix", fin_f, e_fin[0]);
         chk("model_int_rr", {31'b0, int_r}, {31'b0, e_int[1]});
         chk("model_mc_rr", mc_r, e_mc[1]);
         chk("model_fin_rr", fin_r, e_fin[1]);
         chk("inv_int_fin_fix", {31'b0, int_f && (fin_f != 0)}, 32'h0);
         chk("inv_onehot_rr", {31'b0, $countones(fin_r) > 1}, 32'h0);
      end
   end

   task automatic wait_int(input string name, input logic [31:0] exp_f, input logic [31:0] exp_r);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (int_f || int_r) begin
            chk({name, "_int"}, {30'b0, int_f, int_r}, 32'h3);
            chk({name, "_mc_fix"}, mc_f, exp_f);
            chk({name, "_mc_rr"}, mc_r, exp_r);
            return;
         end
      end
      chk({name, "_timeout"}, 32'h0, 32'h1);
   endtask

   // Handler return strobe; the acknowledge is visible one negedge later.
   task automatic mret(input string name, input logic [31:0] exp_f, input logic [31:0] exp_r);
      int_rst = 1'b1;
      @(negedge clk);
      int_rst = 1'b0;
      chk({name, "_fin_fix"}, fin_f, exp_f);
      chk({name, "_fin_rr"}, fin_r, exp_r);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   int pulses;
   logic [31:0] rr_order;

   initial begin
      rst = 1'b1; req = '0; mie = '0; int_rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_int", {30'b0, int_f, int_r}, 32'h0);
      chk("reset_mc", mc_f | mc_r, 32'h0);
      chk("reset_fin", fin_f | fin_r, 32'h0);
      rst = 1'b0;

      // 1: single request on line 5
      mie = 32'hFFFF_FFFF;
      req = 32'h0000_0020;
      wait_int("t1", 32'h8000_0005, 32'h8000_0005);
      @(negedge clk);
      chk("t1_pulse_width", {31'b0, int_f}, 32'h0);
      repeat (2) @(negedge clk);
      mret("t1", 32'h0000_0020, 32'h0000_0020);
      req = '0;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (int_f) pulses++;
      end
      chk("t1_no_second_int", 32'(pulses), 32'h0);

      // 2: masked line, then unmask
      mie = '0;
      req = 32'h0000_0020;
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (int_f || int_r) pulses++;
      end
      chk("t2_masked", 32'(pulses), 32'h0);
      mie = 32'h0000_0020;
      @(negedge clk);
      chk("t2_unmask_int", {31'b0, int_f}, 32'h1);
      chk("t2_unmask_mc", mc_f, 32'h8000_0005);
      mret("t2", 32'h0000_0020, 32'h0000_0020);
      req = '0;
      mie = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);

      // 3: two simultaneous lines, fixed priority order 9 then 11
      req = 32'h0000_0A00;
      wait_int("t3a", 32'h8000_0009, 32'h8000_0009);
      mret("t3a", 32'h0000_0200, 32'h0000_0200);
      req = 32'h0000_0800;
      wait_int("t3b", 32'h8000_000B, 32'h8000_000B);
      mret("t3b", 32'h0000_0800, 32'h0000_0800);
      req = '0;
      repeat (2) @(negedge clk);

      // 4: lines 1 and 2 never released; round-robin alternates, fixed stays on 1
      do_reset();
      req = 32'h0000_0006;
      for (int r = 0; r < 4; r++) begin
         rr_order = (r % 2 == 0) ? 32'd1 : 32'd2;
         wait_int($sformatf("t4_round%0d", r), 32'h8000_0001, 32'h8000_0000 | rr_order);
         @(negedge clk);
         mret($sformatf("t4_round%0d", r), 32'h0000_0002, 32'd1 << rr_order);
      end
      req = '0;
      repeat (3) @(negedge clk);

      // 5: new request and double strobe while line 5 is being handled
      do_reset();
      req = 32'h0000_0020;
      wait_int("t5a", 32'h8000_0005, 32'h8000_0005);
      req = 32'h0000_0021;
      @(negedge clk);
      int_rst = 1'b1;
      @(negedge clk);
      chk("t5_fin_fix", fin_f, 32'h0000_0020);
      chk("t5_fin_rr", fin_r, 32'h0000_0020);
      req = 32'h0000_0001;
      @(negedge clk);
      int_rst = 1'b0;
      chk("t5_single_fin", fin_f | fin_r, 32'h0);
      @(negedge clk);
      chk("t5b_int", {30'b0, int_f, int_r}, 32'h3);
      chk("t5b_mc_fix", mc_f, 32'h8000_0000);
      chk("t5b_mc_rr", mc_r, 32'h8000_0000);
      mret("t5b", 32'h0000_0001, 32'h0000_0001);
      req = '0;
      repeat (2) @(negedge clk);

      // 6: reset while a handler runs abandons the interrupt
      req = 32'h0000_0020;
      wait_int("t6", 32'h8000_0005, 32'h8000_0005);
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_int", {30'b0, int_f, int_r}, 32'h0);
      chk("t6_rst_mc", mc_f | mc_r, 32'h0);
      chk("t6_rst_fin", fin_f | fin_r, 32'h0);
      int_rst = 1'b1;
      @(negedge clk);
      int_rst = 1'b0;
      pulses = 0;
      repeat (3) begin
         if (fin_f != 0 || fin_r != 0) pulses++;
         @(negedge clk);
      end
      chk("t6_no_fin_after_reset", 32'(pulses), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
